// File: rtl/cz80_chk_pkg.sv
// Shared types for the cz80 lockstep checker.
// Holds the checker FSM state encoding and the default configuration
// values used by the checker and its mismatch log FIFO.
package cz80_chk_pkg;

    // Checker run state. HALTED is only left through clear or reset.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } chk_state_e;

    // Default configuration: two 8-bit buses (e.g. T80 q and f_out).
    localparam int CHK_DEF_CHANNELS  = 2;
    localparam int CHK_DEF_WIDTH     = 8;
    localparam int CHK_DEF_LOG_DEPTH = 3;
    localparam int CHK_DEF_CNT_W     = 16;
    localparam int CHK_DEF_TAG_W     = 24;

endpackage : cz80_chk_pkg

// File: rtl/cz80_chk_fifo.sv
// Synchronous FIFO used as the mismatch log of the lockstep checker.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. The head entry is presented
// combinationally from storage and forced to zero while empty, so the
// log outputs never show stale data.
module cz80_chk_fifo #(
    parameter int DATA_W    = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr;
    logic [LOG_DEPTH:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                   (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when a pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && !clear && (!full || do_pop);

    // Pointer update; clear empties the FIFO and overrides push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would chain updates within one edge.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage write port.
    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are valid, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[LOG_DEPTH-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr[LOG_DEPTH-1:0]];

endmodule : cz80_chk_fifo

// File: rtl/cz80_lockstep_checker.sv
// Lockstep comparator for cz80 unit benches and on-FPGA harnesses.
// Each accepted sample carries a stimulus tag plus reference and DUT
// buses. Stage 1 registers the sample; stage 2 compares it, updates the
// saturating counters and sticky flags, logs mismatches into a FIFO and
// optionally halts the stimulus source on the first error.
module cz80_lockstep_checker
    import cz80_chk_pkg::*;
#(
    parameter int CHANNELS  = CHK_DEF_CHANNELS,
    parameter int WIDTH     = CHK_DEF_WIDTH,
    parameter int LOG_DEPTH = CHK_DEF_LOG_DEPTH,
    parameter int CNT_W     = CHK_DEF_CNT_W,
    parameter int TAG_W     = CHK_DEF_TAG_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      enable,
    input  logic                      stop_on_err,
    input  logic [CHANNELS-1:0]       chan_mask,
    input  logic                      sample_valid,
    input  logic [TAG_W-1:0]          sample_tag,
    input  logic [CHANNELS*WIDTH-1:0] ref_data,
    input  logic [CHANNELS*WIDTH-1:0] dut_data,
    output logic                      halt_req,
    output logic                      err,
    output logic                      overflow,
    output logic [CNT_W-1:0]          sample_count,
    output logic [CNT_W-1:0]          mismatch_count,
    output logic                      log_valid,
    input  logic                      log_pop,
    output logic [TAG_W-1:0]          log_tag,
    output logic [CHANNELS-1:0]       log_chan,
    output logic [CHANNELS*WIDTH-1:0] log_ref,
    output logic [CHANNELS*WIDTH-1:0] log_dut
);

    localparam int BUS_W   = CHANNELS * WIDTH;
    localparam int ENTRY_W = TAG_W + CHANNELS + 2 * BUS_W;

    // One mismatch log record; widths follow the module parameters, so the
    // type lives here rather than in the shared package.
    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [CHANNELS-1:0] chan;
        logic [BUS_W-1:0]    ref_bus;
        logic [BUS_W-1:0]    dut_bus;
    } log_entry_t;

    chk_state_e          state;

    logic                s1_valid;
    logic [TAG_W-1:0]    s1_tag;
    logic [BUS_W-1:0]    s1_ref;
    logic [BUS_W-1:0]    s1_dut;
    logic [CHANNELS-1:0] s1_mask;

    logic [CHANNELS-1:0] s2_flags;
    logic                s2_mismatch;

    log_entry_t          push_entry;
    log_entry_t          head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                log_drop;

    // Stage 1: capture the sample only while running; a captured sample
    // always completes stage 2 even if the FSM leaves RUN meanwhile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_ref   <= '0;
            s1_dut   <= '0;
            s1_mask  <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= sample_valid && (state == ST_RUN);
            if (sample_valid && (state == ST_RUN)) begin
                s1_tag  <= sample_tag;
                s1_ref  <= ref_data;
                s1_dut  <= dut_data;
                s1_mask <= chan_mask;
            end
        end
    end

    // Stage 2 compare: a channel mismatches when any bit differs and the
    // channel was enabled in the mask captured with the sample.
    always_comb begin
        // NOTE: default before the loop so every bit is written on every
        // path; otherwise synthesis would infer latches.
        s2_flags = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s2_flags[c] = (|(s1_ref[c*WIDTH +: WIDTH] ^ s1_dut[c*WIDTH +: WIDTH]))
                          & s1_mask[c];
        end
    end

    assign s2_mismatch = s1_valid && (|s2_flags);

    assign push_entry = '{tag: s1_tag, chan: s2_flags, ref_bus: s1_ref, dut_bus: s1_dut};

    // A mismatch is lost only when the log is full and nothing is popped;
    // a full FIFO is never empty, so log_pop alone frees a slot.
    assign log_drop = s2_mismatch && fifo_full && !log_pop;

    cz80_chk_fifo #(
        .DATA_W    (ENTRY_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (s2_mismatch),
        .push_data (push_entry),
        .pop       (log_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    assign log_valid = !fifo_empty;
    assign log_tag   = head_entry.tag;
    assign log_chan  = head_entry.chan;
    assign log_ref   = head_entry.ref_bus;
    assign log_dut   = head_entry.dut_bus;

    // Saturating sample/mismatch counters and sticky error flags; clear
    // in the same cycle as a stage-2 mismatch discards that mismatch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_count   <= '0;
            mismatch_count <= '0;
            err            <= 1'b0;
            overflow       <= 1'b0;
        end else if (clear) begin
            sample_count   <= '0;
            mismatch_count <= '0;
            err            <= 1'b0;
            overflow       <= 1'b0;
        end else if (s1_valid) begin
            if (sample_count != '1) sample_count <= sample_count + CNT_W'(1);
            if (s2_mismatch) begin
                if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
                err <= 1'b1;
                if (log_drop) overflow <= 1'b1;
            end
        end
    end

    // Run-control FSM with registered halt request; halting takes priority
    // over a simultaneous drop of enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            halt_req <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            halt_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (s2_mismatch && stop_on_err) begin
                        state    <= ST_HALTED;
                        halt_req <= 1'b1;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state    <= ST_IDLE;
                    halt_req <= 1'b0;
                end
            endcase
        end
    end

endmodule : cz80_lockstep_checker
